// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - arb_state_e : FSM state encoding (IDLE, ACCESS, DONE)
//   - PORT_IF / PORT_MEM : port index constants for the fetch and data ports
//   - LAT_DEFAULT / CNT_W_DEFAULT : default access latency and counter width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  localparam int unsigned LAT_DEFAULT   = 2;
  localparam int unsigned CNT_W_DEFAULT = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times one memory access.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-low reset (counter clears to 0)
//   load     : load load_val (takes priority over en)
//   load_val : value to load
//   en       : decrement by one; saturates at zero
//   zero     : high while the count is zero
module arb_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one fixed-latency single-port memory between
// the fetch port (0) and the data port (1). sel_o steers the external address
// and write-data muxes; no data passes through this block.
// Build option: define MEM_ARB_RR_EN for round-robin on contention; otherwise
// port 1 has fixed priority.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-low reset
//   req0_i   : fetch port request level
//   req1_i   : data port request level
//   sel_o    : mux select (0 = port 0, 1 = port 1), holds last owner in IDLE
//   mem_en_o : memory enable, high for the LAT access cycles
//   done0_o  : one-cycle completion pulse for port 0
//   done1_o  : one-cycle completion pulse for port 1
//   busy_o   : high whenever the FSM is not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT   = LAT_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic sel_o,
  output logic mem_en_o,
  output logic done0_o,
  output logic done1_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(LAT - 1);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       winner;
  logic       cnt_load, cnt_en, cnt_zero;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // Contention goes to the port that was not served last.
  always_comb begin
    if (req0_i && req1_i) begin
      winner = ~last_q;
    end else begin
      winner = req1_i ? PORT_MEM : PORT_IF;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StDone) begin
      last_d = owner_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last_q <= PORT_MEM;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the data port always wins.
  assign winner = req1_i ? PORT_MEM : PORT_IF;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          owner_d  = winner;
          cnt_load = 1'b1;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (cnt_zero) begin
          state_d = StDone;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      owner_q <= PORT_IF;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  arb_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (cnt_load),
    .load_val(LoadVal),
    .en      (cnt_en),
    .zero    (cnt_zero)
  );

  // owner_q only changes on the IDLE->ACCESS edge, so it also serves as the
  // held select value while idle.
  always_comb begin
    sel_o    = owner_q;
    mem_en_o = (state_q == StAccess);
    done0_o  = (state_q == StDone) && (owner_q == PORT_IF);
    done1_o  = (state_q == StDone) && (owner_q == PORT_MEM);
    busy_o   = (state_q != StIdle);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port, fixed-latency memory between the instruction-fetch port (port 0) and the data-access port (port 1) of the pipelined CPU. It sequences each access through a small state machine and drives `sel_o`, which steers the address/write-data `MUX_2to1` instances in front of the memory. It also returns a one-cycle completion pulse to the served requester. It routes no data itself; all data steering is done by the existing 2:1 multiplexers keyed on `sel_o`.

## Interface
Parameters:
- `LAT`, default 2: memory access cycles per transaction. Legal range 1..15.
- `CNT_W`, default 4: latency counter width. Must satisfy `2**CNT_W > LAT`.

Ports:
- `clk_i` input, 1 bit: single clock. All logic is on the rising edge.
- `rst_i` input, 1 bit: **reset is synchronous and active-low**, sampled on `clk_i`.
- `req0_i` input, 1 bit: port 0 (fetch) request level.
- `req1_i` input, 1 bit: port 1 (data) request level.
- `sel_o` output, 1 bit: mux select. 0 selects port 0, 1 selects port 1.
- `mem_en_o` output, 1 bit: memory enable, high for the whole access.
- `done0_o` output, 1 bit: one-cycle completion pulse for port 0.
- `done1_o` output, 1 bit: one-cycle completion pulse for port 1.
- `busy_o` output, 1 bit: high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - If `req0_i` or `req1_i` is high, latch the winner into `owner`, load the counter with `LAT-1` and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `mem_en_o`=1 and `sel_o`=`owner`.
  - The counter decrements each cycle. When it reaches 0, go to DONE.
- **DONE**
  - `done<owner>_o`=1 for exactly one cycle; the other done output stays 0.
  - `mem_en_o`=0 and `sel_o` holds `owner`.
  - Update `last` to `owner`, then go to IDLE unconditionally.
- In IDLE, `sel_o` holds the last owner, which avoids needless mux toggling.
- Arbitration with exactly one request: that port wins.
- Arbitration with both requests: decided by the policy under Configuration.
- Requests are levels sampled only in IDLE.
  - A request dropped during ACCESS or DONE is ignored: the access completes and `done` still pulses.
  - A request raised during ACCESS waits for IDLE.
- Requesters clear `req` on the edge where they sample `done` high. The IDLE cycle after DONE therefore sees the updated level.
- Outputs are registered, or decoded from registered state only. There is no combinational path from `req*_i` to any output.

## Timing
- Request high in IDLE at cycle 0:
  - ACCESS occupies cycles 1..LAT.
  - DONE is at cycle LAT+1.
  - IDLE is at cycle LAT+2.
- Per-transaction occupancy is LAT+2 cycles. Maximum throughput is one access per LAT+2 cycles.
- `mem_en_o` is high for exactly LAT consecutive cycles per grant.
- `sel_o` is stable from the first ACCESS cycle through DONE.
- Reset values:
  - State IDLE.
  - `sel_o`=0, `mem_en_o`=0, `done0_o`=0, `done1_o`=0, `busy_o`=0.
  - `owner`=0, `last`=1, so port 0 wins the first contested round.
  - Counter=0.
- Reset asserted mid-ACCESS or in DONE: on the next edge all outputs take their reset values and no `done` pulse is issued. Requesters must re-request.
- LAT=1: ACCESS lasts one cycle and the counter is loaded with 0.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- **Defined:** round-robin. When both requests are high in IDLE, the port not equal to `last` wins. Strict alternation under continuous contention: 0,1,0,1…
- **Undefined:** fixed priority. Port 1 (data) always wins contention, which can starve port 0 by design. The `last` register is not implemented.
- Single-request behaviour is identical in both builds.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - the port index constants `PORT_IF`=1'b0 and `PORT_MEM`=1'b1;
  - the default `LAT` and `CNT_W` constants.
- One sub-module, `arb_lat_counter`, provides the loadable down-counter. Its ports are `load`, `load_val`, `en` and `zero` flag.
- FSM, arbitration and output decode live in `mem_port_arbiter`.

## Test plan
- **Reset:** hold `rst_i`=0 for 3 cycles with both requests high. All outputs stay 0. Release; with LAT=2, `mem_en_o` is high at cycles 1–2 with `sel_o`=0 and `done0_o` pulses at cycle 3.
- **Single request:** `req1_i` only, LAT=2. `sel_o`=1 from cycle 1, `mem_en_o` high for 2 cycles, `done1_o` at cycle 3, `busy_o` low at cycle 4.
- **Continuous contention, `MEM_ARB_RR_EN` defined:** both requests held high. Grant order is 0,1,0,1. Each `done` is spaced LAT+2 cycles apart.
- **Continuous contention, macro undefined:** both requests held high for 4 transactions. `done1_o` pulses 4 times and `done0_o` never pulses.
- **Request dropped mid-ACCESS:** drop `req0_i` at cycle 2. `done0_o` still pulses at cycle LAT+1. No second grant is issued.
- **Reset mid-ACCESS (LAT=4):** assert `rst_i`=0 at cycle 2. On the next edge all outputs are 0 and no `done` pulse appears. After release, a contested round grants port 0.
